// File: rtl/voq_scheduler.sv
// Four-ingress / four-egress VOQ scheduler: one ingress per cycle, rotating
// service order and per-ingress round-robin egress pointers, one grant per egress.
module voq_scheduler (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        sched_start,
  input  logic [15:0] voq_empty,
  output logic        sched_busy,
  output logic        sched_done,
  output logic [3:0]  sched_valid,
  output logic [7:0]  sched_egress
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PICK = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      r_state;
  logic [1:0]  r_step;
  logic [1:0]  r_ingress_start;
  logic [3:0]  r_picked;
  logic [1:0]  r_prio_ptr [4];
  logic        r_busy;
  logic        r_done;
  logic [3:0]  r_valid;
  logic [7:0]  r_egress;

  logic [1:0]  w_ing;
  logic [3:0]  w_slice;
  logic [1:0]  w_ptr;
  logic [3:0]  w_avail;
  logic [1:0]  w_cand [4];
  logic [3:0]  w_rot;
  logic        w_grant;
  logic [1:0]  w_pick;

  // The ingress under service and its live VOQ flags, sampled this very cycle.
  assign w_ing   = r_ingress_start + r_step;
  assign w_slice = voq_empty[{w_ing, 2'b00} +: 4];
  assign w_ptr   = r_prio_ptr[w_ing];
  assign w_avail = ~w_slice & ~r_picked;

  // Candidate k is the egress k positions past this ingress's priority pointer.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_cand
      assign w_cand[gi] = w_ptr + 2'(gi);
      assign w_rot[gi]  = w_avail[w_cand[gi]];
    end
  endgenerate

  always_comb begin
    w_grant = 1'b0;
    w_pick  = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_grant = 1'b1;
        w_pick  = w_cand[k];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state         <= IDLE;
      r_step          <= 2'd0;
      r_ingress_start <= 2'd0;
      r_picked        <= 4'd0;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
      r_valid         <= 4'd0;
      r_egress        <= 8'd0;
      for (int i = 0; i < 4; i++) begin
        r_prio_ptr[i] <= 2'd0;
      end
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (sched_start) begin
            r_state  <= PICK;
            r_busy   <= 1'b1;
            r_step   <= 2'd0;
            r_picked <= 4'd0;
            r_valid  <= 4'd0;
            r_egress <= 8'd0;
          end
        end
        PICK: begin
          if (w_grant) begin
            r_valid[w_ing]                 <= 1'b1;
            r_egress[{w_ing, 1'b0} +: 2]   <= w_pick;
            r_picked                       <= r_picked | (4'b0001 << w_pick);
            r_prio_ptr[w_ing]              <= w_pick + 2'd1;
          end
          r_step <= r_step + 2'd1;
          if (r_step == 2'd3) begin
            r_state         <= DONE;
            r_done          <= 1'b1;
            r_ingress_start <= r_ingress_start + 2'd1;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign sched_busy   = r_busy;
  assign sched_done   = r_done;
  assign sched_valid  = r_valid;
  assign sched_egress = r_egress;

endmodule

// File: tb/tb_voq_scheduler.sv
// Randomized bench for voq_scheduler with an epoch-level reference model.
module tb_voq_scheduler;

  logic        clk;
  logic        reset_n;
  logic        sched_start;
  logic [15:0] voq_empty;
  logic        sched_busy;
  logic        sched_done;
  logic [3:0]  sched_valid;
  logic [7:0]  sched_egress;

  int n_total;
  int n_bad;
  int done_cnt;

  int m_start;
  int m_ptr [4];
  logic [3:0] m_valid;
  logic [7:0] m_egress;

  voq_scheduler dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .sched_start  (sched_start),
    .voq_empty    (voq_empty),
    .sched_busy   (sched_busy),
    .sched_done   (sched_done),
    .sched_valid  (sched_valid),
    .sched_egress (sched_egress)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reset_n && sched_done) done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_start = 0;
    for (int i = 0; i < 4; i++) m_ptr[i] = 0;
    m_valid  = '0;
    m_egress = '0;
  endtask

  // One epoch: ingress (start+s)%4 sees emp[s]; first non-empty unclaimed
  // egress walking up from its pointer wins.
  task automatic model_epoch(input logic [15:0] emp [4]);
    bit claimed [4];
    for (int e = 0; e < 4; e++) claimed[e] = 0;
    m_valid  = '0;
    m_egress = '0;
    for (int s = 0; s < 4; s++) begin
      int ing;
      ing = (m_start + s) % 4;
      for (int k = 0; k < 4; k++) begin
        int e;
        e = (m_ptr[ing] + k) % 4;
        if (!emp[s][4*ing + e] && !claimed[e]) begin
          claimed[e]          = 1;
          m_valid[ing]        = 1'b1;
          m_egress[2*ing +: 2] = e[1:0];
          m_ptr[ing]          = (e + 1) % 4;
          break;
        end
      end
    end
    m_start = (m_start + 1) % 4;
  endtask

  task automatic run_epoch(input logic [15:0] emp [4], input bit spam, input string tag);
    int d0;
    @(posedge clk); #1;
    sched_start = 1'b1;
    voq_empty   = emp[0];
    @(posedge clk); #1;
    d0 = done_cnt;
    sched_start = spam;
    @(negedge clk);
    chk({tag, ":busy0"}, 32'(sched_busy), 32'd1);
    chk({tag, ":valid_clr"}, 32'(sched_valid), 32'd0);
    for (int s = 1; s < 4; s++) begin
      @(posedge clk); #1;
      voq_empty = emp[s];
      @(negedge clk);
      chk({tag, ":early_done"}, 32'(sched_done), 32'd0);
    end
    model_epoch(emp);
    @(posedge clk);
    @(negedge clk);
    chk({tag, ":done"}, 32'(sched_done), 32'd1);
    chk({tag, ":busy_done"}, 32'(sched_busy), 32'd1);
    chk({tag, ":valid"}, 32'(sched_valid), 32'(m_valid));
    chk({tag, ":egress"}, 32'(sched_egress), 32'(m_egress));
    @(posedge clk); #1;
    sched_start = 1'b0;
    voq_empty   = 16'($urandom);
    @(negedge clk);
    chk({tag, ":idle_busy"}, 32'(sched_busy), 32'd0);
    chk({tag, ":hold_valid"}, 32'(sched_valid), 32'(m_valid));
    chk({tag, ":hold_egress"}, 32'(sched_egress), 32'(m_egress));
    @(posedge clk);
    @(negedge clk);
    chk({tag, ":no_restart"}, 32'(sched_busy), 32'd0);
    chk({tag, ":one_done"}, 32'(done_cnt - d0), 32'd1);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(negedge clk);
    model_reset();
    chk("rst:busy", 32'(sched_busy), 32'd0);
    chk("rst:done", 32'(sched_done), 32'd0);
    chk("rst:valid", 32'(sched_valid), 32'd0);
    chk("rst:egress", 32'(sched_egress), 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  initial begin
    logic [15:0] emp [4];
    n_total     = 0;
    n_bad       = 0;
    done_cnt    = 0;
    reset_n     = 1'b0;
    sched_start = 1'b0;
    voq_empty   = 16'h0000;
    model_reset();
    repeat (2) @(posedge clk);
    do_reset();

    for (int s = 0; s < 4; s++) emp[s] = 16'h0000;
    run_epoch(emp, 0, "all_full1");
    chk("d1_egress", 32'(sched_egress), 32'h0000_00E4);
    run_epoch(emp, 0, "all_full2");
    chk("d2_egress", 32'(sched_egress), 32'h0000_0039);

    do_reset();
    for (int s = 0; s < 4; s++) emp[s] = 16'hBBBB;
    run_epoch(emp, 0, "only_e2");
    chk("only_e2_valid", 32'(sched_valid), 32'h1);
    chk("only_e2_egress", 32'(sched_egress), 32'h2);

    for (int s = 0; s < 4; s++) emp[s] = 16'hFFFF;
    run_epoch(emp, 1, "all_empty_spam");
    chk("all_empty_valid", 32'(sched_valid), 32'h0);

    // Abort during step 2: no done pulse, then first epoch repeats from scratch.
    begin
      int d0;
      d0 = done_cnt;
      @(posedge clk); #1;
      sched_start = 1'b1;
      voq_empty   = 16'h0000;
      repeat (3) @(posedge clk);
      #1;
      sched_start = 1'b0;
      reset_n     = 1'b0;
      #1;
      chk("abort:busy", 32'(sched_busy), 32'd0);
      chk("abort:valid", 32'(sched_valid), 32'd0);
      chk("abort:egress", 32'(sched_egress), 32'd0);
      repeat (3) @(posedge clk);
      #1;
      reset_n = 1'b1;
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("abort:no_done", 32'(done_cnt - d0), 32'd0);
      chk("abort:idle", 32'(sched_busy), 32'd0);
      for (int s = 0; s < 4; s++) emp[s] = 16'h0000;
      run_epoch(emp, 0, "post_abort");
      chk("post_abort_egress", 32'(sched_egress), 32'h0000_00E4);
    end

    for (int n = 0; n < 40; n++) begin
      for (int s = 0; s < 4; s++) begin
        case ($urandom_range(0, 3))
          0: emp[s] = 16'($urandom);
          1: emp[s] = 16'($urandom) | 16'($urandom);
          2: emp[s] = 16'($urandom) & 16'($urandom);
          default: emp[s] = 16'($urandom) | 16'($urandom) | 16'($urandom);
        endcase
      end
      run_epoch(emp, 1'($urandom_range(0, 1)), $sformatf("rnd%0d", n));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
